// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the digit-count sizing helper.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Smallest digit count whose decimal range covers every WIDTH-bit unsigned value.
    function automatic int required_digits(input int width);
        logic [127:0] maxVal;
        int           d;
        maxVal = (128'd1 << width) - 128'd1;
        d      = 0;
        while (maxVal != 128'd0) begin
            maxVal = maxVal / 128'd10;
            d++;
        end
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= DIGIT_W'(5)) ? digit_i + DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter: one add-3 column reused for WIDTH shift cycles.
// The result register only changes on the done edge, so displays never see partial values.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           bin,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    generate
        if ((DIGITS < required_digits(WIDTH)) || (DIGIT_W * DIGITS < WIDTH)) begin : g_bad_digits
            $error("bcd_seq_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]   work_q;
    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   work_d;
    logic [BCD_W-1:0]   bcd_q;
    logic               done_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit_i (work_q[DIGIT_W*i +: DIGIT_W]),
            .digit_o (work_adj[DIGIT_W*i +: DIGIT_W])
        );
    end

    // Correct first, then shift the binary MSB into the bottom of the BCD register.
    assign work_d = {work_adj[BCD_W-2:0], bin_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    bin_q  <= bin_q << 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        bcd_q   <= work_d;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: directed scenarios plus a random sweep
// compared against a decimal-arithmetic reference model.
module tb_bcd_seq_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int LIMIT  = 100;

    logic                  clk;
    logic                  reset_n;
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    int errors = 0;
    int checks = 0;

    bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of the value by repeated division.
    function automatic logic [4*DIGITS-1:0] refBcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises start for one edge with the given value; returns just after the accepting edge.
    task automatic launch(input logic [WIDTH-1:0] value, input bit holdStart);
        start = 1'b1;
        bin   = value;
        step();
        if (!holdStart) start = 1'b0;
    endtask

    // Steps until done; edges counts edges after the accepting edge, -1 on timeout.
    task automatic waitDone(output int edges, output int busyCycles, output int overlap);
        bit seen;
        seen       = 1'b0;
        edges      = 0;
        busyCycles = busy ? 1 : 0;
        overlap    = 0;
        while (!seen && edges < LIMIT) begin
            step();
            edges++;
            if (busy) busyCycles++;
            if (busy && done) overlap++;
            if (done) seen = 1'b1;
        end
        if (!seen) edges = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = '0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (bcd !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bcd: got %h expected 00000", bcd);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_zero();
        int edges, busyCycles, overlap;
        launch('0, 1'b0);
        waitDone(edges, busyCycles, overlap);
        checks++;
        if (edges !== WIDTH) begin
            errors++;
            $display("[TB] FAIL zero_latency: done %0d edges after accept, expected %0d", edges, WIDTH);
        end
        checks++;
        if (busyCycles !== WIDTH) begin
            errors++;
            $display("[TB] FAIL zero_busy_len: busy for %0d cycles, expected %0d", busyCycles, WIDTH);
        end
        checks++;
        if (bcd !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL zero_value: got %h expected 00000", bcd);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_one_cycle: done=%b expected 0", done);
        end
    endtask

    task automatic test_values();
        logic [WIDTH-1:0]    vals [3] = '{16'd9999, 16'd65535, 16'd10};
        logic [4*DIGITS-1:0] exps [3] = '{20'h09999, 20'h65535, 20'h00010};
        int edges, busyCycles, overlap;
        for (int i = 0; i < 3; i++) begin
            launch(vals[i], 1'b0);
            waitDone(edges, busyCycles, overlap);
            checks++;
            if (edges !== WIDTH || bcd !== exps[i]) begin
                errors++;
                $display("[TB] FAIL value_%0d: got %h after %0d edges, expected %h after %0d",
                         vals[i], bcd, edges, exps[i], WIDTH);
            end
            step();
        end
    endtask

    task automatic test_start_while_busy();
        logic [4*DIGITS-1:0] prior;
        int edges, dones, holdErr, extraDone;
        prior = bcd;
        launch(16'd1234, 1'b0);
        edges   = 0;
        dones   = 0;
        holdErr = 0;
        repeat (4) begin
            step();
            edges++;
            if (done) dones++;
            if (bcd !== prior) holdErr++;
        end
        start = 1'b1;
        bin   = 16'd4321;
        step();
        edges++;
        start = 1'b0;
        bin   = 16'hFFFF;
        while (!done && edges < LIMIT) begin
            if (bcd !== prior) holdErr++;
            step();
            edges++;
        end
        if (done) dones++;
        checks++;
        if (edges !== WIDTH || bcd !== 20'h01234) begin
            errors++;
            $display("[TB] FAIL busy_ignore: got %h after %0d edges, expected 01234 after %0d",
                     bcd, edges, WIDTH);
        end
        checks++;
        if (holdErr !== 0) begin
            errors++;
            $display("[TB] FAIL bcd_hold: %0d cycles changed early, expected 0", holdErr);
        end
        extraDone = 0;
        repeat (25) begin
            step();
            if (done || busy) extraDone++;
        end
        checks++;
        if (extraDone !== 0 || dones !== 1) begin
            errors++;
            $display("[TB] FAIL single_done: dones=%0d extra activity=%0d, expected 1 and 0",
                     dones, extraDone);
        end
    endtask

    task automatic test_back_to_back();
        int edges, busyCycles, overlap;
        launch(16'd321, 1'b0);
        waitDone(edges, busyCycles, overlap);
        start = 1'b1;
        bin   = 16'd500;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accept: busy=%b expected 1", busy);
        end
        waitDone(edges, busyCycles, overlap);
        checks++;
        if (edges !== WIDTH || bcd !== 20'h00500) begin
            errors++;
            $display("[TB] FAIL b2b_value: got %h after %0d edges, expected 00500 after %0d",
                     bcd, edges, WIDTH);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int edges, busyCycles, overlap, stray;
        launch(16'd777, 1'b0);
        repeat (7) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (bcd !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state: bcd=%h busy=%b done=%b expected 00000 0 0", bcd, busy, done);
        end
        stray = 0;
        repeat (20) begin
            step();
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: %0d active cycles, expected 0", stray);
        end
        launch(16'd42, 1'b0);
        waitDone(edges, busyCycles, overlap);
        checks++;
        if (edges !== WIDTH || bcd !== 20'h00042) begin
            errors++;
            $display("[TB] FAIL after_abort: got %h after %0d edges, expected 00042", bcd, edges);
        end
        step();
    endtask

    task automatic test_random();
        int edges, busyCycles, overlap;
        int unsigned v;
        bit hold;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) v = ($urandom_range(0, 1) == 1) ? 65535 : 0;
            else                           v = $urandom_range(0, 65535);
            hold = ($urandom_range(0, 1) == 1);
            launch(WIDTH'(v), hold);
            bin = WIDTH'($urandom);
            waitDone(edges, busyCycles, overlap);
            checks++;
            if (edges !== WIDTH || bcd !== refBcd(v)) begin
                errors++;
                $display("[TB] FAIL random_%0d: bin=%0d got %h after %0d edges, expected %h",
                         i, v, bcd, edges, refBcd(v));
            end
            checks++;
            if (overlap !== 0 || busyCycles !== WIDTH) begin
                errors++;
                $display("[TB] FAIL random_busy_%0d: overlap=%0d busy=%0d expected 0 %0d",
                         i, overlap, busyCycles, WIDTH);
            end
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
        end
        start = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
